// File: rtl/encoder_16x4_seq_if.sv
// Handshake bundle for encoder_16x4_seq: request-vector load side and code output side.
// master = surrounding logic (producer + consumer), slave = the encoder.
interface encoder_16x4_seq_if;
   logic        req_valid;
   logic [15:0] req;
   logic        req_ready;
   logic        out_valid;
   logic [3:0]  out_code;
   logic        out_ready;
   logic        done;

   modport master (
      output req_valid, req, out_ready,
      input  req_ready, out_valid, out_code, done
   );

   modport slave (
      input  req_valid, req, out_ready,
      output req_ready, out_valid, out_code, done
   );
endinterface

// File: rtl/encoder_16x4_seq.sv
// Sequential 16-to-4 encoder: latches a request vector and emits one set-bit index per handshake.
// Fixed priority (highest first) by default; `define ENC_ROUND_ROBIN_EN for round-robin scan order.
module encoder_16x4_seq (
   input  logic              clk,
   input  logic              rst_n,
   encoder_16x4_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] pending_q, pending_d;
   logic [3:0]  sel;
   logic        req_ready_c, out_valid_c, done_c;
   logic [3:0]  out_code_c;

`ifdef ENC_ROUND_ROBIN_EN
   logic [3:0]  last_q, last_d;
   logic [3:0]  idx;

   // Scan last-1 downward with wrap; offset 16 lands on last itself, so it is checked last.
   always_comb begin
      sel = '0;
      idx = '0;
      for (int k = 16; k >= 1; k--) begin
         idx = last_q - 4'(k);
         if (pending_q[idx]) sel = idx;
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int k = 0; k < 16; k++) begin
         if (pending_q[k]) sel = 4'(k);
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
`ifdef ENC_ROUND_ROBIN_EN
      last_d      = last_q;
`endif
      req_ready_c = 1'b0;
      out_valid_c = 1'b0;
      out_code_c  = '0;
      done_c      = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) begin
               pending_d = bus.req;
               state_d   = (bus.req != '0) ? EMIT : DONE;
            end
         end
         EMIT: begin
            out_valid_c = 1'b1;
            out_code_c  = sel;
            if (bus.out_ready) begin
               pending_d = pending_q & ~(16'h0001 << sel);
`ifdef ENC_ROUND_ROBIN_EN
               last_d    = sel;
`endif
               if (pending_d == '0) state_d = DONE;
            end
         end
         DONE: begin
            done_c  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
`ifdef ENC_ROUND_ROBIN_EN
         last_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
`ifdef ENC_ROUND_ROBIN_EN
         last_q    <= last_d;
`endif
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_code  = out_code_c;
   assign bus.done      = done_c;

endmodule
